// File: rtl/clint_multi_if.sv
// rtl/clint_multi_if.sv - peripheral-port request/response bundle for clint_multi
interface clint_multi_if;
  logic        clint_valid;
  logic        clint_instr;
  logic [31:0] clint_addr;
  logic [31:0] clint_wdata;
  logic [3:0]  clint_wstrb;
  logic [31:0] clint_rdata;
  logic        clint_ready;

  modport master (
    output clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
    input  clint_rdata, clint_ready
  );

  modport slave (
    input  clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
    output clint_rdata, clint_ready
  );
endinterface

// File: rtl/clint_multi.sv
// rtl/clint_multi.sv - multi-hart core-local interruptor: shared mtime, per-hart msip/mtimecmp
module clint_multi #(
  parameter int          NUM_HARTS      = 4,
  parameter int          CLK_DIVIDER    = 49,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                 clock,
  input  logic                 reset,
  clint_multi_if.slave         bus,
  output logic [63:0]          clint_mtime,
  output logic [NUM_HARTS-1:0] clint_msip,
  output logic [NUM_HARTS-1:0] clint_mtip
);

  localparam logic [29:0] CMP_BASE = 30'h1000;
  localparam logic [29:0] MTIME_LO = 30'h2FFE;
  localparam logic [29:0] MTIME_HI = 30'h2FFF;

  logic [31:0]          count;
  logic                 tick;
  logic [63:0]          mtime;
  logic [63:0]          mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip;
  logic [NUM_HARTS-1:0] mtip;
  logic                 ready;
  logic [31:0]          rdata;
  logic [31:0]          read_value;
  logic [29:0]          word;
  logic                 wr;
  logic                 unused;

  assign word   = bus.clint_addr[31:2];
  assign wr     = bus.clint_valid && (bus.clint_wstrb != 4'b0000);
  assign unused = ^{bus.clint_instr, bus.clint_addr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = st[i] ? wd[i*8 +: 8] : old[i*8 +: 8];
    end
    return res;
  endfunction

  // Only decoded harts are visited, so any unmapped offset falls through as 0.
  always_comb begin
    read_value = 32'h0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (word == 30'(h))                read_value = {31'h0, msip[h]};
      if (word == CMP_BASE + 30'(2*h))   read_value = mtimecmp[h][31:0];
      if (word == CMP_BASE + 30'(2*h+1)) read_value = mtimecmp[h][63:32];
    end
    if (word == MTIME_LO) read_value = mtime[31:0];
    if (word == MTIME_HI) read_value = mtime[63:32];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= 32'h0;
      tick  <= 1'b0;
      mtime <= 64'h0;
      msip  <= '0;
      mtip  <= '0;
      ready <= 1'b0;
      rdata <= 32'h0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= MTIMECMP_RESET;
    end else begin
      if (count == 32'(CLK_DIVIDER)) begin
        count <= 32'h0;
        tick  <= 1'b1;
      end else begin
        count <= count + 32'h1;
        tick  <= 1'b0;
      end

      ready <= bus.clint_valid;
      rdata <= bus.clint_valid ? read_value : 32'h0;

      // A software write to mtime wins over the tick increment for that cycle.
      if (wr && word == MTIME_LO)
        mtime <= {mtime[63:32], merge(mtime[31:0], bus.clint_wdata, bus.clint_wstrb)};
      else if (wr && word == MTIME_HI)
        mtime <= {merge(mtime[63:32], bus.clint_wdata, bus.clint_wstrb), mtime[31:0]};
      else if (tick)
        mtime <= mtime + 64'h1;

      for (int h = 0; h < NUM_HARTS; h++) begin
        mtip[h] <= (mtime >= mtimecmp[h]);
        if (wr && word == 30'(h) && bus.clint_wstrb[0])
          msip[h] <= bus.clint_wdata[0];
        if (wr && word == CMP_BASE + 30'(2*h))
          mtimecmp[h][31:0] <= merge(mtimecmp[h][31:0], bus.clint_wdata, bus.clint_wstrb);
        if (wr && word == CMP_BASE + 30'(2*h+1))
          mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], bus.clint_wdata, bus.clint_wstrb);
      end
    end
  end

  assign bus.clint_ready = ready;
  assign bus.clint_rdata = rdata;
  assign clint_mtime     = mtime;
  assign clint_msip      = msip;
  assign clint_mtip      = mtip;

endmodule

// File: tb/tb_clint_multi.sv
// tb/tb_clint_multi.sv - randomized and directed checks of clint_multi against a behavioural model
module tb_clint_multi;
  localparam int NH  = 4;
  localparam int DIV = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  clint_multi_if bus();
  logic [63:0]   mtime;
  logic [NH-1:0] msip;
  logic [NH-1:0] mtip;

  clint_multi #(
    .NUM_HARTS(NH),
    .CLK_DIVIDER(DIV),
    .MTIMECMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .clint_mtime(mtime),
    .clint_msip(msip),
    .clint_mtip(mtip)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: registers as plain variables, tick phase from edge count.
  logic [63:0]   m_mtime;
  logic [63:0]   m_cmp [NH];
  logic [NH-1:0] m_msip;
  logic [NH-1:0] m_mtip;
  logic          m_ready;
  logic [31:0]   m_rdata;
  int            edges;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] aw;
    int          idx;
    aw = {a[31:2], 2'b00};
    if (aw < 32'(4*NH)) return {31'h0, m_msip[aw/4]};
    if (aw >= 32'h4000 && aw < 32'h4000 + 32'(8*NH)) begin
      idx = int'((aw - 32'h4000) / 8);
      return ((aw % 8) == 4) ? m_cmp[idx][63:32] : m_cmp[idx][31:0];
    end
    if (aw == 32'hBFF8) return m_mtime[31:0];
    if (aw == 32'hBFFC) return m_mtime[63:32];
    return 32'h0;
  endfunction

  function automatic logic [31:0] bytes(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (st[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  task automatic model_edge();
    logic [31:0]   aw;
    logic [31:0]   rd;
    logic [NH-1:0] nxt_mtip;
    logic          inc;
    logic          mt_written;
    int            idx;
    if (!reset) begin
      m_mtime = 64'h0;
      m_msip  = '0;
      m_mtip  = '0;
      m_ready = 1'b0;
      m_rdata = 32'h0;
      for (int h = 0; h < NH; h++) m_cmp[h] = 64'hFFFF_FFFF_FFFF_FFFF;
      edges = 0;
      return;
    end
    edges++;
    inc = (edges > 1) && ((edges - 1) % (DIV + 1) == 0);
    rd  = bus.clint_valid ? model_read(bus.clint_addr) : 32'h0;
    for (int h = 0; h < NH; h++) nxt_mtip[h] = (m_mtime >= m_cmp[h]);
    mt_written = 1'b0;
    aw = {bus.clint_addr[31:2], 2'b00};
    if (bus.clint_valid && bus.clint_wstrb != 4'h0) begin
      if (aw < 32'(4*NH)) begin
        if (bus.clint_wstrb[0]) m_msip[aw/4] = bus.clint_wdata[0];
      end else if (aw >= 32'h4000 && aw < 32'h4000 + 32'(8*NH)) begin
        idx = int'((aw - 32'h4000) / 8);
        if ((aw % 8) == 4) m_cmp[idx][63:32] = bytes(m_cmp[idx][63:32], bus.clint_wdata, bus.clint_wstrb);
        else               m_cmp[idx][31:0]  = bytes(m_cmp[idx][31:0],  bus.clint_wdata, bus.clint_wstrb);
      end else if (aw == 32'hBFF8) begin
        m_mtime[31:0] = bytes(m_mtime[31:0], bus.clint_wdata, bus.clint_wstrb);
        mt_written = 1'b1;
      end else if (aw == 32'hBFFC) begin
        m_mtime[63:32] = bytes(m_mtime[63:32], bus.clint_wdata, bus.clint_wstrb);
        mt_written = 1'b1;
      end
    end
    if (inc && !mt_written) m_mtime = m_mtime + 64'h1;
    m_mtip  = nxt_mtip;
    m_ready = bus.clint_valid;
    m_rdata = rd;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("ready", bus.clint_ready, m_ready);
    check("rdata", bus.clint_rdata, m_rdata);
    check("mtime", mtime, m_mtime);
    check("msip", msip, m_msip);
    check("mtip", mtip, m_mtip);
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    bus.clint_valid = v;
    bus.clint_instr = 1'($urandom);
    bus.clint_addr  = a;
    bus.clint_wdata = d;
    bus.clint_wstrb = s;
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    drive(1'b1, a, d, s);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    logic        found;
    logic [31:0] a;
    logic [31:0] d;
    int          sel;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    reset = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    check("rst_mtime", mtime, 64'h0);
    check("rst_mtip", mtip, 64'h0);
    check("rst_msip", msip, 64'h0);
    repeat (8) cycle();
    check("mtime_after_8", mtime, 64'd2);

    access(32'h0008, 32'h1, 4'hF);
    check("msip_set", msip, 64'b0100);
    access(32'h0008, 32'h0, 4'h0);
    check("msip_rd_ready", bus.clint_ready, 1'b1);
    check("msip_rd", bus.clint_rdata, 64'h1);
    cycle();
    check("rdata_idle", bus.clint_rdata, 64'h0);
    access(32'h0008, 32'h0, 4'hF);
    check("msip_clr", msip, 64'h0);

    access(32'h4000, 32'h1122_3344, 4'hF);
    access(32'h4000, 32'hAABB_CCDD, 4'b0010);
    access(32'h4000, 32'h0, 4'h0);
    check("byte_strobe", bus.clint_rdata, 64'h1122_CC44);

    access(32'hBFFC, 32'hFFFF_FFFF, 4'hF);
    access(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    found = 1'b0;
    for (int i = 0; i < 4*(DIV+1) && !found; i++) begin
      cycle();
      if (mtime == 64'h0) found = 1'b1;
    end
    check("mtime_wrap", found, 1'b1);
    for (int p = 0; p <= DIV; p++) begin
      access(32'hBFF8, 32'h100, 4'hF);
      repeat (p) cycle();
    end

    access(32'hBFF8, 32'h0, 4'hF);
    access(32'h400C, 32'h0, 4'hF);
    access(32'h4008, 32'd20, 4'hF);
    found = 1'b0;
    for (int i = 0; i < 30*(DIV+1) && !found; i++) begin
      cycle();
      if (mtip[1]) found = 1'b1;
    end
    check("mtip1_rise", found, 1'b1);
    check("mtip_others", mtip, 64'b0010);
    access(32'h400C, 32'h1, 4'hF);
    cycle();
    check("mtip1_fall", mtip, 64'h0);

    access(32'h0010, 32'h1, 4'hF);
    access(32'h0010, 32'h0, 4'h0);
    check("unmapped_h4_ready", bus.clint_ready, 1'b1);
    check("unmapped_h4_rdata", bus.clint_rdata, 64'h0);
    access(32'h8000, 32'hFFFF_FFFF, 4'hF);
    access(32'h8000, 32'h0, 4'h0);
    check("unmapped_8000", bus.clint_rdata, 64'h0);
    check("unmapped_msip", msip, 64'h0);

    drive(1'b1, 32'hBFF8, 32'h0, 4'h0);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("rst_ready", bus.clint_ready, 1'b0);
    check("rst_mtime2", mtime, 64'h0);

    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom % 6);
      case (sel)
        0:       a = 32'($urandom_range(0, NH)) * 4 + 32'($urandom % 4);
        1, 2:    a = 32'h4000 + 32'($urandom_range(0, 2*NH+1)) * 4;
        3:       a = ($urandom % 2 == 0) ? 32'hBFF8 : 32'hBFFC;
        4:       a = $urandom;
        default: a = 32'hBFF8;
      endcase
      d = ($urandom % 4 == 0) ? $urandom : 32'($urandom_range(0, 300));
      if (a[2] && a >= 32'h4000 && a < 32'h4040 && $urandom % 4 != 0) d = 32'h0;
      drive(1'($urandom % 2), a, d, ($urandom % 2 == 0) ? 4'h0 : 4'($urandom));
      reset = ($urandom % 300 == 0) ? 1'b0 : 1'b1;
      cycle();
    end
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
